// File: rtl/cl_serial_regbank.sv
// Camera Link serial control: 8N1 UART RX/TX, frame parser and flat register bank.
// Define CL_SERIAL_CHECKSUM_EN to require a trailing XOR checksum byte on each frame.
module cl_serial_regbank #(
  parameter int unsigned CLK_DIV     = 217,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned REG_BYTES   = 3,
  parameter int unsigned TIMEOUT_CYC = 2170000,
  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int unsigned RW = 8 * REG_BYTES
) (
  input  logic                   clk_sys,
  input  logic                   rst_sys,
  input  logic                   ser_rx,
  output logic                   ser_tx,
  output logic [NUM_REGS*RW-1:0] reg_flat,
  output logic                   reg_wr_stb,
  output logic [AW-1:0]          reg_wr_addr,
  output logic                   busy,
  output logic [7:0]             err_cnt
);

  localparam logic [15:0] DivM1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HalfM1 = 16'(CLK_DIV / 2 - 1);
  localparam int unsigned RespW  = 8 * (REG_BYTES + 1);

  // ---------------- RX ----------------
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_st_e;

  rx_st_e      rx_st_q;
  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;
  logic        rx_valid_q, rx_ferr_q;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      rx_st_q    <= RxIdle;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= ser_rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      unique case (rx_st_q)
        RxIdle: begin
          if (rx_s3_q && !rx_s2_q) begin
            rx_cnt_q <= '0;
            rx_st_q  <= RxStart;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HalfM1) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            // Line back high at mid start bit: treat as glitch.
            rx_st_q  <= rx_s2_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxData: begin
          if (rx_cnt_q == DivM1) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_st_q <= RxStop;
            else rx_bit_q <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxStop: begin
          if (rx_cnt_q == DivM1) begin
            rx_st_q <= RxIdle;
            if (rx_s2_q) rx_valid_q <= 1'b1;
            else rx_ferr_q <= 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_st_q <= RxIdle;
      endcase
    end
  end

  // ---------------- TX ----------------
  logic        tx_busy_q, ser_tx_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic [8:0]  tx_sh_q;
  logic        tx_finish, tx_load;
  logic [7:0]  tx_data;

  assign tx_finish = tx_busy_q && (tx_cnt_q == DivM1) && (tx_bit_q == 4'd9);

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      tx_busy_q <= 1'b0;
      ser_tx_q  <= 1'b1;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
    end else if (tx_load) begin
      tx_busy_q <= 1'b1;
      ser_tx_q  <= 1'b0;
      tx_sh_q   <= {1'b1, tx_data};
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == DivM1) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
        end else begin
          ser_tx_q <= tx_sh_q[0];
          tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
          tx_bit_q <= tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 16'd1;
      end
    end
  end

  assign ser_tx = ser_tx_q;

  // ---------------- Parser / register bank ----------------
`ifdef CL_SERIAL_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StChk, StExec, StResp} st_e;
`else
  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StExec, StResp} st_e;
`endif

  st_e             state_q;
  logic [7:0]      cmd_q, addr_q;
  logic [RW-1:0]   data_q;
  logic [2:0]      byte_cnt_q;
  logic [31:0]     tmo_q;
  logic [RespW-1:0] resp_q;
  logic [2:0]      resp_left_q;
  logic [RW-1:0]   regs_q [NUM_REGS];
  logic            reg_wr_stb_q;
  logic [AW-1:0]   reg_wr_addr_q;
  logic [7:0]      err_q;
`ifdef CL_SERIAL_CHECKSUM_EN
  logic [7:0]      chk_q;
  logic            chk_ok_q;
  st_e             after_payload;
  assign after_payload = StChk;
`else
  st_e             after_payload;
  assign after_payload = StExec;
`endif

  logic          in_frame, tmo_hit, ferr_hit, frame_ok, nak, err_inc;
  logic [AW-1:0] idx;

  assign idx      = addr_q[AW-1:0];
`ifdef CL_SERIAL_CHECKSUM_EN
  assign in_frame = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData) ||
                    (state_q == StChk);
  assign frame_ok = ((cmd_q == 8'h01) || (cmd_q == 8'h02)) && (32'(addr_q) < NUM_REGS) &&
                    chk_ok_q;
`else
  assign in_frame = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);
  assign frame_ok = ((cmd_q == 8'h01) || (cmd_q == 8'h02)) && (32'(addr_q) < NUM_REGS);
`endif
  assign tmo_hit  = in_frame && !rx_valid_q && (tmo_q == 32'(TIMEOUT_CYC - 1));
  // Framing errors while answering are discarded like any other received byte.
  assign ferr_hit = rx_ferr_q && (state_q != StExec) && (state_q != StResp);
  assign nak      = (state_q == StExec) && !frame_ok;
  assign err_inc  = tmo_hit || ferr_hit || nak;
  assign tx_load  = (state_q == StResp) && (resp_left_q != 3'd0) && (!tx_busy_q || tx_finish);
  assign tx_data  = resp_q[RespW-1 -: 8];

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q       <= StIdle;
      cmd_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      byte_cnt_q    <= '0;
      tmo_q         <= '0;
      resp_q        <= '0;
      resp_left_q   <= '0;
      reg_wr_stb_q  <= 1'b0;
      reg_wr_addr_q <= '0;
      err_q         <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
`ifdef CL_SERIAL_CHECKSUM_EN
      chk_q         <= '0;
      chk_ok_q      <= 1'b0;
`endif
    end else begin
      reg_wr_stb_q <= 1'b0;
      if (err_inc && (err_q != 8'hff)) err_q <= err_q + 8'd1;
      if (in_frame) tmo_q <= rx_valid_q ? 32'd0 : tmo_q + 32'd1;
      else tmo_q <= '0;
      if (tx_load) begin
        resp_q      <= resp_q << 8;
        resp_left_q <= resp_left_q - 3'd1;
      end
      unique case (state_q)
        StIdle: if (rx_valid_q && (rx_sh_q == 8'h55)) state_q <= StCmd;
        StCmd: begin
          if (rx_valid_q) begin
            cmd_q   <= rx_sh_q;
            state_q <= StAddr;
`ifdef CL_SERIAL_CHECKSUM_EN
            chk_q   <= rx_sh_q;
`endif
          end
        end
        StAddr: begin
          if (rx_valid_q) begin
            addr_q     <= rx_sh_q;
            byte_cnt_q <= '0;
            // Unknown commands are sized like a read.
            state_q    <= (cmd_q == 8'h01) ? StData : after_payload;
`ifdef CL_SERIAL_CHECKSUM_EN
            chk_q      <= chk_q ^ rx_sh_q;
`endif
          end
        end
        StData: begin
          if (rx_valid_q) begin
            data_q     <= RW'({data_q, rx_sh_q});
            byte_cnt_q <= byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'(REG_BYTES - 1)) state_q <= after_payload;
`ifdef CL_SERIAL_CHECKSUM_EN
            chk_q      <= chk_q ^ rx_sh_q;
`endif
          end
        end
`ifdef CL_SERIAL_CHECKSUM_EN
        StChk: begin
          if (rx_valid_q) begin
            chk_ok_q <= (rx_sh_q == chk_q);
            state_q  <= StExec;
          end
        end
`endif
        StExec: begin
          state_q     <= StResp;
          resp_left_q <= 3'd1;
          resp_q      <= {8'h15, {RW{1'b0}}};
          if (frame_ok && (cmd_q == 8'h01)) begin
            regs_q[idx]   <= data_q;
            reg_wr_stb_q  <= 1'b1;
            reg_wr_addr_q <= idx;
            resp_q        <= {8'h06, {RW{1'b0}}};
          end else if (frame_ok) begin
            resp_q      <= {8'h06, regs_q[idx]};
            resp_left_q <= 3'(REG_BYTES + 1);
          end
        end
        StResp: if (tx_finish && (resp_left_q == 3'd0)) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (ferr_hit || tmo_hit) state_q <= StIdle;
    end
  end

  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_flat
    assign reg_flat[i*RW +: RW] = regs_q[i];
  end

  assign reg_wr_stb  = reg_wr_stb_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign busy        = (state_q != StIdle);
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_cl_serial_regbank.sv
// Directed bench for cl_serial_regbank: table of frames plus timeout, framing, reset and
// glitch sequences. Builds with or without CL_SERIAL_CHECKSUM_EN.
module tb_cl_serial_regbank;

  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned NUM_REGS    = 16;
  localparam int unsigned REG_BYTES   = 3;
  localparam int unsigned TIMEOUT_CYC = 300;
  localparam int unsigned RW          = 24;
  localparam int unsigned AW          = 4;

  logic                   clk_sys = 1'b0;
  logic                   rst_sys = 1'b1;
  logic                   ser_rx  = 1'b1;
  logic                   ser_tx;
  logic [NUM_REGS*RW-1:0] reg_flat;
  logic                   reg_wr_stb;
  logic [AW-1:0]          reg_wr_addr;
  logic                   busy;
  logic [7:0]             err_cnt;

  cl_serial_regbank #(
    .CLK_DIV    (CLK_DIV),
    .NUM_REGS   (NUM_REGS),
    .REG_BYTES  (REG_BYTES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_sys    (rst_sys),
    .ser_rx     (ser_rx),
    .ser_tx     (ser_tx),
    .reg_flat   (reg_flat),
    .reg_wr_stb (reg_wr_stb),
    .reg_wr_addr(reg_wr_addr),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;
  logic [7:0] rx_q[$];
  int stop_errs = 0;
  int stb_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0;

  typedef struct {
    logic [63:0] frame;
    int          len;
    logic [31:0] resp;
    int          resp_len;
    int          reg_idx;
    logic [23:0] reg_val;
    int          stbs;
    int          err;
  } vec_t;

  vec_t vecs[6];

  // Serial receiver model for ser_tx, sampling at mid-bit on falling clock edges.
  initial begin
    logic [7:0] mb;
    forever begin
      @(negedge clk_sys);
      if (!rst_sys && ser_tx === 1'b0) begin
        repeat (CLK_DIV / 2) @(negedge clk_sys);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk_sys);
          mb[i] = ser_tx;
        end
        repeat (CLK_DIV) @(negedge clk_sys);
        if (ser_tx !== 1'b1) stop_errs++;
        rx_q.push_back(mb);
      end
    end
  end

  always @(negedge clk_sys) begin
    if (reg_wr_stb === 1'b1) begin
      stb_cnt++;
      last_wr_addr = reg_wr_addr;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk_sys) ser_rx = 1'b0;
    repeat (CLK_DIV - 1) @(negedge clk_sys);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys) ser_rx = b[i];
      repeat (CLK_DIV - 1) @(negedge clk_sys);
    end
    @(negedge clk_sys) ser_rx = stop;
    repeat (CLK_DIV - 1) @(negedge clk_sys);
    @(negedge clk_sys) ser_rx = 1'b1;
  endtask

  // Sends len bytes MSB-first from f, appending the XOR checksum when that build is selected.
  task automatic send_frame(input logic [63:0] f, input int len);
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    for (int k = 0; k < len; k++) begin
      b = f[63-8*k -: 8];
      send_byte(b, 1'b1);
      if (k > 0) cs = cs ^ b;
    end
`ifdef CL_SERIAL_CHECKSUM_EN
    send_byte(cs, 1'b1);
`endif
  endtask

  task automatic wait_rx(input int n, input string name);
    for (int c = 0; c < 2000 && rx_q.size() < n; c++) @(negedge clk_sys);
    checks++;
    if (rx_q.size() < n) begin
      failures++;
      $display("FAIL %s: got %0d response bytes expected %0d", name, rx_q.size(), n);
    end
  endtask

  task automatic check_resp(input logic [31:0] resp, input int n, input string name);
    logic [7:0] e;
    wait_rx(n, name);
    repeat (CLK_DIV + 4) @(negedge clk_sys);
    chk({name, "_len"}, rx_q.size(), n);
    for (int j = 0; j < n; j++) begin
      e = resp[31-8*j -: 8];
      if (j < rx_q.size()) chk({name, "_byte"}, rx_q[j], e);
    end
  endtask

  initial begin
    int s0;
    int exp_err;
    vecs[0] = '{64'h5501031234560000, 6, 32'h06000000, 1, 3, 24'h123456, 1, 0};
    vecs[1] = '{64'h5502030000000000, 3, 32'h06123456, 4, 3, 24'h123456, 0, 0};
    vecs[2] = '{64'h550110AABBCC0000, 6, 32'h15000000, 1, 0, 24'h000000, 0, 1};
    vecs[3] = '{64'h5507000000000000, 3, 32'h15000000, 1, 0, 24'h000000, 0, 2};
    vecs[4] = '{64'h5501000102030000, 6, 32'h06000000, 1, 0, 24'h010203, 1, 2};
    vecs[5] = '{64'h5502000000000000, 3, 32'h06010203, 4, 0, 24'h010203, 0, 2};

    repeat (5) @(negedge clk_sys);
    chk("rst_ser_tx", 32'(ser_tx), 32'd1);
    chk("rst_reg_flat", 32'(reg_flat != '0), 32'd0);
    chk("rst_wr_stb", 32'(reg_wr_stb), 32'd0);
    chk("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_sys = 1'b0;
    repeat (5) @(negedge clk_sys);

    for (int v = 0; v < 6; v++) begin
      rx_q.delete();
      s0 = stb_cnt;
      send_frame(vecs[v].frame, vecs[v].len);
      check_resp(vecs[v].resp, vecs[v].resp_len, $sformatf("vec%0d_resp", v));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_reg", v), 32'(reg_flat[vecs[v].reg_idx*RW +: RW]),
          32'(vecs[v].reg_val));
      chk($sformatf("vec%0d_stbs", v), stb_cnt - s0, vecs[v].stbs);
      if (vecs[v].stbs != 0)
        chk($sformatf("vec%0d_wr_addr", v), 32'(last_wr_addr), vecs[v].reg_idx);
      chk($sformatf("vec%0d_err", v), 32'(err_cnt), vecs[v].err);
    end
    exp_err = 2;

`ifdef CL_SERIAL_CHECKSUM_EN
    // Checksum should be 01^00^AA^AA^AA = AB; 00 must be rejected.
    rx_q.delete();
    s0 = stb_cnt;
    send_byte(8'h55, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'hAA, 1'b1);
    send_byte(8'h00, 1'b1);
    check_resp(32'h15000000, 1, "badchk_resp");
    exp_err++;
    chk("badchk_reg0", 32'(reg_flat[0 +: RW]), 32'h010203);
    chk("badchk_stbs", stb_cnt - s0, 0);
    chk("badchk_err", 32'(err_cnt), exp_err);
`endif

    // Partial frame abandoned by the host.
    rx_q.delete();
    send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (3) @(negedge clk_sys);
    chk("tmo_busy_mid", 32'(busy), 32'd1);
    repeat (TIMEOUT_CYC + 50) @(negedge clk_sys);
    exp_err++;
    chk("tmo_busy_after", 32'(busy), 32'd0);
    chk("tmo_err", 32'(err_cnt), exp_err);
    chk("tmo_no_resp", rx_q.size(), 0);

    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_frame(64'h5502000000000000, 3);
    check_resp(32'h06010203, 4, "lead_resp");
    chk("lead_err", 32'(err_cnt), exp_err);

    rx_q.delete();
    send_byte(8'h55, 1'b1);
    send_byte(8'h3C, 1'b0);
    repeat (10) @(negedge clk_sys);
    exp_err++;
    chk("ferr_busy", 32'(busy), 32'd0);
    chk("ferr_err", 32'(err_cnt), exp_err);
    chk("ferr_no_resp", rx_q.size(), 0);

    // Reset while a read response is on the wire.
    rx_q.delete();
    send_frame(64'h5502030000000000, 3);
    wait_rx(1, "rst_first_byte");
    for (int c = 0; c < 100 && ser_tx !== 1'b0; c++) @(negedge clk_sys);
    chk("rst_tx_low_before", 32'(ser_tx), 32'd0);
    @(negedge clk_sys) rst_sys = 1'b1;
    @(posedge clk_sys);
    #1;
    chk("midrst_ser_tx", 32'(ser_tx), 32'd1);
    chk("midrst_reg_flat", 32'(reg_flat != '0), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_err", 32'(err_cnt), 32'd0);
    @(negedge clk_sys) rst_sys = 1'b0;
    repeat (12 * CLK_DIV) @(negedge clk_sys);
    rx_q.delete();

    // One-cycle low glitch must not start a byte that would swallow the next frame.
    @(negedge clk_sys) ser_rx = 1'b0;
    @(negedge clk_sys) ser_rx = 1'b1;
    repeat (4) @(negedge clk_sys);
    send_frame(64'h5502030000000000, 3);
    check_resp(32'h06000000, 4, "glitch_resp");
    chk("glitch_err", 32'(err_cnt), 32'd0);

    for (int i = 0; i < 260; i++) send_byte(8'h00, 1'b0);
    repeat (10) @(negedge clk_sys);
    chk("err_saturate", 32'(err_cnt), 32'd255);
    chk("tx_stop_bits", stop_errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cl_serial_regbank.md
Name: cl_serial_regbank

Overview:
Parametrised successor to the Camera Link serial control path: an 8N1 UART receiver/transmitter plus frame parser and register bank in one clk_sys domain. Host frames arrive on the CL SerTC line, which is already converted to single-ended. Frames write or read NUM_REGS registers of REG_BYTES bytes each and are answered with ACK, NAK or read data on SerTFG. The flattened register bus feeds the integration, frame, window, test-image and training-word consumers.

Parameters:
CLK_DIV, 217, clk_sys cycles per UART bit (25 MHz / 115200); legal range 4..65535.
NUM_REGS, 16, number of registers; address width AW = clog2(NUM_REGS).
REG_BYTES, 3, bytes per register (1..4); register width RW = 8*REG_BYTES.
TIMEOUT_CYC, 2170000, idle clk_sys cycles between bytes that abort a partial frame.

Ports:
clk_sys  in  1  system clock.
rst_sys  in  1  synchronous active-high reset.
ser_rx  in  1  SerTC data, asynchronous, idle high.
ser_tx  out  1  SerTFG data, idle high.
reg_flat  out  NUM_REGS*RW  register contents; register i occupies bits [i*RW +: RW].
reg_wr_stb  out  1  one-cycle pulse when a register is written.
reg_wr_addr  out  AW  address of the last write; valid while reg_wr_stb is high.
busy  out  1  high from the first header byte until the last response stop bit.
err_cnt  out  8  saturating count of NAKs, framing errors and timeouts.

Behaviour:
- Reset (synchronous, active-high) values: ser_tx=1, reg_flat=0, reg_wr_stb=0, reg_wr_addr=0, busy=0, err_cnt=0. The parser goes to IDLE and the UARTs go idle. A reset mid-frame or mid-response drops everything immediately; ser_tx goes high on the next edge.
- RX path:
  - ser_rx passes through a 2-flop synchroniser.
  - A falling edge starts bit timing. The start bit is resampled at CLK_DIV/2; if it is high there, the event is a glitch: return to idle, no error.
  - Data is sampled every CLK_DIV cycles, 8 bits LSB first, then the stop bit.
  - Stop bit = 0 is a framing error: byte discarded, parser goes to IDLE, err_cnt+1, no response.
  - rx_valid pulses 1 cycle after the stop-bit sample.
- Frame format: 0x55, CMD, ADDR, then DATA[REG_BYTES] MSB first (write only), then optional CHK. CMD 0x01 = write, 0x02 = read.
- Parser states: IDLE -> CMD -> ADDR -> DATA (write only, counts REG_BYTES) -> CHK (only if the feature is enabled) -> EXEC -> RESP -> IDLE.
  - IDLE ignores every byte except 0x55.
  - CMD other than 0x01/0x02, ADDR >= NUM_REGS, or a checksum mismatch: frame is consumed fully (byte count based on the CMD value; an invalid CMD counts as a read), response is NAK, no write.
- EXEC:
  - Valid write: register updated, reg_wr_stb=1 for exactly 1 cycle, reg_wr_addr=ADDR. Response: 0x06.
  - Valid read: value latched in EXEC. Response: 0x06 then REG_BYTES bytes MSB first.
  - NAK response: 0x15.
- RESP: TX sends 8N1, LSB first, CLK_DIV cycles per bit, with no idle gap between response bytes. RX bytes arriving during RESP are discarded without error. After the last stop bit, state is IDLE and busy=0.
- Timeout: a counter clears on each rx_valid while in CMD..CHK. Reaching TIMEOUT_CYC sends the parser to IDLE with no response and err_cnt+1.
- Latency: reg_wr_stb asserts 2 cycles after rx_valid of the final frame byte. The TX start bit begins 3 cycles after that rx_valid.
- err_cnt saturates at 255. A framing error together with a timeout in the same cycle counts once.

Optional Feature:
CL_SERIAL_CHECKSUM_EN
- Defined: frame carries a trailing CHK byte = XOR of CMD, ADDR and all DATA bytes (0x55 excluded). A mismatch produces NAK.
- Undefined: no CHK state and no checksum logic; the frame ends after the last DATA byte (write) or ADDR (read).

Test Plan:
1. CLK_DIV=4, REG_BYTES=3, feature off. Send 55 01 03 12 34 56 -> reg_flat[3*24+:24]=0x123456, reg_wr_stb single pulse, reg_wr_addr=3, ser_tx sends 0x06.
2. After test 1, send 55 02 03 -> ser_tx sends 06 12 34 56 back-to-back, no register change, busy drops after the last stop bit.
3. Send 55 01 10 AA BB CC (addr 16 >= NUM_REGS), then 55 07 00 -> two 0x15 responses, no write, err_cnt=2.
4. Feature on. Send 55 01 00 01 02 03 01 -> write, ACK. Send 55 01 00 01 02 03 00 -> NAK, register 0 stays 0x010203.
5. Send 55 01 and let the line idle TIMEOUT_CYC cycles -> no response, err_cnt+1. Then send 00 00 55 02 00 -> leading bytes ignored, read responds normally. A byte with stop bit 0 -> err_cnt+1.
6. Assert rst_sys mid-response -> ser_tx=1 and reg_flat=0 on the next edge. A 1-cycle low glitch on ser_rx -> no byte received.
